// File: rtl/pulpino_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulpino_ctrl_pkg
//  Description : Shared types and constants for the PULPino run sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulpino_ctrl_pkg;

  // Run sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RELEASE = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    FINISH  = 3'd4
  } run_state_t;

  // Bit positions inside the status word
  localparam int ST_RD   = 0;
  localparam int ST_WR   = 1;
  localparam int ST_GPIO = 2;
  localparam int ST_TO   = 3;

  // Cycles the core reset stays released before the masters are started
  localparam int LP_RELEASE_CYCLES = 2;

  // Width of the run-cycle field in the status word
  localparam int LP_CYC_FIELD_W = 28;

endpackage : pulpino_ctrl_pkg
`default_nettype wire

// File: rtl/pulpino_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : pulpino_watchdog
//  Description : Saturating run-cycle counter with a limit compare. A limit
//                of zero disables the trip output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulpino_watchdog #(
  parameter int C_TIMEOUT_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [C_TIMEOUT_WIDTH-1:0] limit,
  output logic [C_TIMEOUT_WIDTH-1:0] count,
  output logic                       trip
);

  localparam logic [C_TIMEOUT_WIDTH-1:0] c_one = {{(C_TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  logic [C_TIMEOUT_WIDTH-1:0] r_count;
  logic                       w_at_max;

  assign w_at_max = &r_count;

  // Count enabled cycles, holding at all ones instead of wrapping
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !w_at_max) begin
      r_count <= r_count + c_one;
    end
  end

  // The trip fires in the cycle whose count equals limit-1, so the run
  // ends after exactly 'limit' enabled cycles
  assign trip  = enable && (limit != '0) && (r_count == (limit - c_one));
  assign count = r_count;

endmodule : pulpino_watchdog
`default_nettype wire

// File: rtl/pulpino_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pulpino_run_ctrl
//  Description : Run sequencer for the PULPino L3 kernel datapath. Handles
//                the host ap_* handshake, latches the run scalars, releases
//                the core reset, starts both AXI masters, waits for their
//                done pulses under a watchdog and reports a status word.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulpino_run_ctrl
  import pulpino_ctrl_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_TIMEOUT_WIDTH    = 32,
  parameter bit C_DONE_HOLD        = 1'b1
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  // host handshake
  input  logic                          ap_start,
  output logic                          ap_done,
  output logic                          ap_idle,
  output logic                          ap_ready,
  // run scalars
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_i,
  input  logic                          spi_enable_i,
  input  logic                          use_qspi_i,
  input  logic [31:0]                   spi_addr_idx_i,
  input  logic [31:0]                   instr_num_i,
  input  logic [C_TIMEOUT_WIDTH-1:0]    timeout_cycles_i,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset_o,
  output logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_o,
  output logic                          spi_enable_o,
  output logic                          use_qspi_o,
  output logic [31:0]                   spi_addr_idx_o,
  output logic [31:0]                   instr_num_o,
  // datapath control
  output logic                          rd_start,
  output logic                          wr_start,
  input  logic                          rd_done,
  input  logic                          wr_done,
  input  logic                          gpio_out_en,
  output logic                          core_rst_n,
  output logic [31:0]                   status
);

  localparam logic [1:0] c_rel_last = 2'(LP_RELEASE_CYCLES - 1);

  run_state_t                    r_state;
  logic [1:0]                    r_rel_cnt;
  logic                          r_ap_done;
  logic                          r_ap_ready;
  logic                          r_start_pulse;
  logic [3:0]                    r_sts;

  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  r_xfer;
  logic                          r_spi_en;
  logic                          r_qspi;
  logic [31:0]                   r_spi_idx;
  logic [31:0]                   r_instr;
  logic [C_TIMEOUT_WIDTH-1:0]    r_timeout;

  logic                          w_accept;
  logic                          w_running;
  logic                          w_trip;
  logic                          w_rd_all;
  logic                          w_wr_all;
  logic [C_TIMEOUT_WIDTH-1:0]    w_count;
  logic [LP_CYC_FIELD_W-1:0]     w_cyc_field;

  // A new run is accepted only from IDLE
  assign w_accept  = (r_state == IDLE) && ap_start;
  assign w_running = (r_state == RUN);

  // Done status including a pulse arriving in the current RUN cycle
  assign w_rd_all = r_sts[ST_RD] | rd_done;
  assign w_wr_all = r_sts[ST_WR] | wr_done;

  pulpino_watchdog #(
    .C_TIMEOUT_WIDTH (C_TIMEOUT_WIDTH)
  ) u_watchdog (
    .aclk     (aclk),
    .areset_n (areset_n),
    .clear    (w_accept),
    .enable   (w_running),
    .limit    (r_timeout),
    .count    (w_count),
    .trip     (w_trip)
  );

  // Sequencer: handshake, reset release, master start and run tracking
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state       <= IDLE;
      r_rel_cnt     <= 2'd0;
      r_ap_done     <= 1'b0;
      r_ap_ready    <= 1'b0;
      r_start_pulse <= 1'b0;
      r_sts         <= 4'd0;
    end else begin
      r_ap_ready    <= 1'b0;
      r_start_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ap_start) begin
            r_ap_ready <= 1'b1;
            r_ap_done  <= 1'b0;
            r_sts      <= 4'd0;
            r_rel_cnt  <= 2'd0;
            r_state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (r_rel_cnt == c_rel_last) begin
            r_state <= START;
          end else begin
            r_rel_cnt <= r_rel_cnt + 2'd1;
          end
        end
        START: begin
          r_start_pulse <= 1'b1;
          r_state       <= RUN;
        end
        RUN: begin
          r_sts[ST_RD]   <= w_rd_all;
          r_sts[ST_WR]   <= w_wr_all;
          r_sts[ST_GPIO] <= r_sts[ST_GPIO] | gpio_out_en;
          // The watchdog wins over a coinciding final done
          if (w_trip) begin
            r_sts[ST_TO] <= 1'b1;
            r_ap_done    <= 1'b1;
            r_state      <= FINISH;
          end else if (w_rd_all && w_wr_all) begin
            r_ap_done <= 1'b1;
            r_state   <= FINISH;
          end
        end
        FINISH: begin
          if (!C_DONE_HOLD) begin
            r_ap_done <= 1'b0;
          end
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Scalar latch: captured on acceptance, stable until the next acceptance
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_addr    <= '0;
      r_xfer    <= '0;
      r_spi_en  <= 1'b0;
      r_qspi    <= 1'b0;
      r_spi_idx <= 32'd0;
      r_instr   <= 32'd0;
      r_timeout <= '0;
    end else if (w_accept) begin
      r_addr    <= ctrl_addr_offset_i;
      r_xfer    <= ctrl_xfer_size_i;
      r_spi_en  <= spi_enable_i;
      r_qspi    <= use_qspi_i;
      r_spi_idx <= spi_addr_idx_i;
      r_instr   <= instr_num_i;
      r_timeout <= timeout_cycles_i;
    end
  end

  // Run-cycle field of the status word saturates at 28 bits
  generate
    if (C_TIMEOUT_WIDTH > LP_CYC_FIELD_W) begin : g_cyc_wide
      assign w_cyc_field = (|w_count[C_TIMEOUT_WIDTH-1:LP_CYC_FIELD_W]) ?
                           {LP_CYC_FIELD_W{1'b1}} : w_count[LP_CYC_FIELD_W-1:0];
    end else if (C_TIMEOUT_WIDTH == LP_CYC_FIELD_W) begin : g_cyc_exact
      assign w_cyc_field = w_count;
    end else begin : g_cyc_narrow
      assign w_cyc_field = {{(LP_CYC_FIELD_W-C_TIMEOUT_WIDTH){1'b0}}, w_count};
    end
  endgenerate

  assign status = {w_cyc_field, r_sts};

  // The core is held in reset while idle and after a watchdog trip
  assign core_rst_n = (r_state == RELEASE) || (r_state == START) || (r_state == RUN) ||
                      ((r_state == FINISH) && !r_sts[ST_TO]);

  assign ap_done  = r_ap_done;
  assign ap_idle  = (r_state == IDLE);
  assign ap_ready = r_ap_ready;
  assign rd_start = r_start_pulse;
  assign wr_start = r_start_pulse;

  assign ctrl_addr_offset_o = r_addr;
  assign ctrl_xfer_size_o   = r_xfer;
  assign spi_enable_o       = r_spi_en;
  assign use_qspi_o         = r_qspi;
  assign spi_addr_idx_o     = r_spi_idx;
  assign instr_num_o        = r_instr;

endmodule : pulpino_run_ctrl
`default_nettype wire

// File: doc/pulpino_run_ctrl.md
Name: pulpino_run_ctrl

Overview:
Run sequencer for the PULPino L3 kernel datapath (AXI read master -> PULPino L4 -> AXI write master). It accepts the host ap_start/ap_done handshake and latches the run scalars (SPI config, instruction count, transfer size, address offset) for the whole run. It issues single-cycle start pulses to the read and write masters, tracks both done pulses plus the core's gpio_out_en, and enforces a cycle-count watchdog. It reports ap_done/ap_idle/ap_ready and a status word with run cycles and the termination cause.

Parameters:
C_M_AXI_ADDR_WIDTH, 64, width of the address offset
C_XFER_SIZE_WIDTH, 32, width of the transfer size
C_TIMEOUT_WIDTH, 32, width of the watchdog and cycle counters
C_DONE_HOLD, 1, 1 = ap_done stays high until the next ap_start; 0 = ap_done is a 1-cycle pulse

Ports:
aclk  in  1  kernel clock; every flop is on the rising edge
areset_n  in  1  synchronous, active-low reset
ap_start  in  1  host start, level; sampled only in IDLE
ap_done  out  1  run finished
ap_idle  out  1  high in IDLE
ap_ready  out  1  1-cycle pulse when scalars are latched
ctrl_addr_offset_i  in  C_M_AXI_ADDR_WIDTH  buffer base address
ctrl_xfer_size_i  in  C_XFER_SIZE_WIDTH  transfer size in bytes
spi_enable_i, use_qspi_i  in  1 each  SPI boot configuration
spi_addr_idx_i, instr_num_i  in  32 each  SPI index and instruction count
timeout_cycles_i  in  C_TIMEOUT_WIDTH  watchdog limit; 0 disables the watchdog
ctrl_addr_offset_o, ctrl_xfer_size_o, spi_enable_o, use_qspi_o, spi_addr_idx_o, instr_num_o  out  matching widths  latched copies, stable for the whole run
rd_start  out  1  start pulse to the read master
wr_start  out  1  start pulse to the write master
rd_done  in  1  read master done pulse
wr_done  in  1  write master done pulse
gpio_out_en  in  1  core end-of-program flag
core_rst_n  out  1  active-low reset to L4 and the stream path
status  out  32  bit0 = read done, bit1 = write done, bit2 = gpio seen, bit3 = timeout, bits31:4 = run cycles, saturating

Behaviour:
- Reset (areset_n = 0, sampled at a clock edge):
  - state = IDLE, ap_idle = 1.
  - ap_done, ap_ready, rd_start, wr_start = 0; core_rst_n = 0.
  - All latched outputs and status are cleared to 0.
- IDLE:
  - ap_idle = 1 and core_rst_n = 0.
  - On ap_start = 1: latch all scalar inputs, pulse ap_ready for 1 cycle, clear status and counters, go to RELEASE.
- RELEASE:
  - core_rst_n = 1.
  - Hold for 2 cycles (fixed count) so the L4 reset synchronizers settle, then go to START.
- START:
  - rd_start and wr_start are high together for exactly 1 cycle, then go to RUN.
  - Start-to-pulse latency is 4 cycles after the ap_start sample edge.
- RUN:
  - The cycle counter increments every cycle.
  - rd_done, wr_done and gpio_out_en set sticky status bits; any of them may arrive in any order or in the same cycle.
  - When both the rd and wr bits are set (including the cycle in which the last one arrives), go to FINISH.
  - A watchdog trip takes priority when it coincides with a final done.
- Watchdog:
  - Trips when timeout_cycles_i != 0 and the cycle counter == timeout_cycles_i - 1.
  - On a trip: set bit3, drive core_rst_n = 0, go to FINISH.
  - Outstanding master done pulses are not awaited. The host must reset the masters via areset_n before the next run.
- FINISH:
  - Assert ap_done.
  - C_DONE_HOLD = 1: hold ap_done until ap_start is seen in IDLE; the state moves to IDLE on the next cycle and ap_done clears when the new run is accepted.
  - C_DONE_HOLD = 0: 1-cycle pulse, then IDLE.
  - status remains readable until the next run.
- Masters and status:
  - Done pulses received in IDLE are ignored.
  - A second ap_start during a run is ignored; ap_ready is not pulsed.
  - The cycle counter saturates at all ones and does not wrap.
  - status[31:4] holds counter[27:0], saturated.
- Reset mid-run: areset_n = 0 at any state returns to the reset values on the next edge; no done pulse is issued.
- The latched outputs do not change between ap_ready and the next ap_ready.

Decomposition:
- Shared package pulpino_ctrl_pkg holds:
  - the state enum run_state_t {IDLE, RELEASE, START, RUN, FINISH};
  - the status bit-index localparams (ST_RD, ST_WR, ST_GPIO, ST_TO);
  - LP_RELEASE_CYCLES = 2.
- One sub-module, pulpino_watchdog: saturating counter plus compare, with clear, enable and trip outputs.
- The top-level FSM and the scalar latch stay in pulpino_run_ctrl.

Test Plan:
- Nominal run: ap_start held, rd_done at cycle 20, wr_done at cycle 35 -> rd_start/wr_start 1-cycle pulse 4 cycles after start; ap_done rises 1 cycle after wr_done; status bits[1:0] = 11, bit3 = 0.
- Simultaneous events: rd_done, wr_done and gpio_out_en all in the same cycle -> FINISH next cycle; status[2:0] = 111.
- Timeout: timeout_cycles_i = 50 and wr_done never arrives -> trip at RUN cycle 50; core_rst_n = 0; ap_done = 1; status bit3 = 1; bit1 = 0.
- Scalar stability: change instr_num_i from 0x100 to 0x200 mid-run -> instr_num_o stays 0x100 until the next ap_ready.
- Reset mid-run: areset_n low for 1 cycle during RUN -> all outputs at reset values next edge; no ap_done; ap_idle = 1.
- Done mode: with C_DONE_HOLD = 0, ap_done is exactly 1 cycle. Back-to-back run with ap_start held high -> second ap_ready 2 cycles after the first ap_done, and status cleared.
